// File: rtl/drr_arbiter_if.sv
// drr_arbiter_if: request/quantum inputs and grant/ownership outputs of the DRR arbiter.
`default_nettype none

interface drr_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int QWID     = 4
);
  localparam int OWID = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]      reqs;
  logic [NUM_REQS*QWID-1:0] quantums;
  logic [NUM_REQS-1:0]      gnt;
  logic                     gnt_vld;
  logic [OWID-1:0]          owner;
  logic [QWID-1:0]          credit_left;

  modport master (
    input  reqs, quantums,
    output gnt, gnt_vld, owner, credit_left
  );

  modport slave (
    output reqs, quantums,
    input  gnt, gnt_vld, owner, credit_left
  );
endinterface

`default_nettype wire

// File: rtl/drr_arbiter.sv
// drr_arbiter: deficit-round-robin style arbiter; each owner is granted for up to its
// quantum of cycles, then service rotates to the next eligible requester.
`default_nettype none

module drr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int QWID     = 4
) (
  input  wire           clk,
  input  wire           rst,
  drr_arbiter_if.master bus
);
  localparam int OWID = $clog2(NUM_REQS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t              r_state;
  logic [OWID-1:0]     r_owner;
  logic [QWID-1:0]     r_credit;

  logic [NUM_REQS-1:0] w_elig;
  logic                w_found;
  logic [OWID-1:0]     w_next;
  logic [QWID-1:0]     w_next_q;
  logic [NUM_REQS-1:0] w_gnt;
  int unsigned         w_sum;

  // A zero quantum makes a requester permanently ineligible.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_elig
    assign w_elig[gi] = bus.reqs[gi] && (bus.quantums[gi*QWID +: QWID] != '0);
  end

  // Scan owner+1 .. owner so the current owner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_next  = r_owner;
    w_sum   = 0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      w_sum = int'(r_owner) + k;
      if (w_sum >= NUM_REQS) begin
        w_sum = w_sum - NUM_REQS;
      end
      if (!w_found && w_elig[w_sum]) begin
        w_found = 1'b1;
        w_next  = OWID'(w_sum);
      end
    end
  end

  assign w_next_q = bus.quantums[int'(w_next)*QWID +: QWID];

  always_comb begin
    w_gnt = '0;
    if (r_state == ST_SERVE && bus.reqs[r_owner] && r_credit != '0) begin
      w_gnt[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWID'(NUM_REQS - 1);
      r_credit <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_SERVE;
            r_owner  <= w_next;
            r_credit <= w_next_q;
          end
        end
        ST_SERVE: begin
          if (w_gnt != '0 && r_credit > QWID'(1)) begin
            r_credit <= r_credit - QWID'(1);
          end else if (w_found) begin
            // Exhausted or owner dropped: hand over without a bubble, leftover credit is lost.
            r_owner  <= w_next;
            r_credit <= w_next_q;
          end else begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.gnt_vld     = |w_gnt;
  assign bus.owner       = r_owner;
  assign bus.credit_left = r_credit;

endmodule

`default_nettype wire

// File: tb/tb_drr_arbiter.sv
// tb_drr_arbiter: table-driven directed vectors plus hand-written multi-cycle sequences.
`default_nettype none

module tb_drr_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  drr_arbiter_if #(.NUM_REQS(4), .QWID(4)) bus ();

  drr_arbiter #(.NUM_REQS(4), .QWID(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  reqs;
    logic [15:0] q;
    logic        chk;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [3:0]  credit;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] q,
                     input logic c, input logic [3:0] g, input logic [1:0] o,
                     input logic [3:0] cr);
    vec_t v;
    v.rst = r; v.reqs = rq; v.q = q; v.chk = c; v.gnt = g; v.owner = o; v.credit = cr;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [15:0] q);
    @(negedge clk);
    rst          = r;
    bus.reqs     = rq;
    bus.quantums = q;
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] g, input logic [1:0] o,
                     input logic [3:0] cr);
    n_checks++;
    if (bus.gnt !== g) begin
      n_fails++;
      $display("FAIL %s gnt: got %b expected %b", name, bus.gnt, g);
    end
    n_checks++;
    if (bus.gnt_vld !== (|g)) begin
      n_fails++;
      $display("FAIL %s gnt_vld: got %b expected %b", name, bus.gnt_vld, |g);
    end
    n_checks++;
    if (bus.owner !== o) begin
      n_fails++;
      $display("FAIL %s owner: got %0d expected %0d", name, bus.owner, o);
    end
    n_checks++;
    if (bus.credit_left !== cr) begin
      n_fails++;
      $display("FAIL %s credit_left: got %0d expected %0d", name, bus.credit_left, cr);
    end
    n_checks++;
    if ($countones(bus.gnt) > 1) begin
      n_fails++;
      $display("FAIL %s onehot: got %b expected at most one bit", name, bus.gnt);
    end
  endtask

  initial begin
    logic [1:0] exp_o[18];
    logic [3:0] exp_c[18];
    logic [3:0] g;
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b1;
    bus.reqs     = '0;
    bus.quantums = '0;

    // Reset hold, idle with nothing eligible, single requester, reset abort, mixed quanta.
    add(1, 4'b1111, 16'h2222, 0, 4'b0000, 2'd3, 4'd0);
    add(1, 4'b1111, 16'h2222, 1, 4'b0000, 2'd3, 4'd0);
    add(1, 4'b1111, 16'h2222, 1, 4'b0000, 2'd3, 4'd0);
    add(0, 4'b0000, 16'h2222, 1, 4'b0000, 2'd3, 4'd0);
    add(0, 4'b0000, 16'h2222, 1, 4'b0000, 2'd3, 4'd0);
    add(0, 4'b0001, 16'h0003, 1, 4'b0000, 2'd3, 4'd0);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd3);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd2);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd1);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd3);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd2);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd1);
    add(0, 4'b0001, 16'h0003, 1, 4'b0001, 2'd0, 4'd3);
    add(1, 4'b1111, 16'h3012, 1, 4'b0001, 2'd0, 4'd2);
    add(0, 4'b1111, 16'h3012, 1, 4'b0000, 2'd3, 4'd0);
    add(0, 4'b1111, 16'h3012, 1, 4'b0001, 2'd0, 4'd2);
    add(0, 4'b1111, 16'h3012, 1, 4'b0001, 2'd0, 4'd1);
    add(0, 4'b1111, 16'h3012, 1, 4'b0010, 2'd1, 4'd1);
    add(0, 4'b1111, 16'h3012, 1, 4'b1000, 2'd3, 4'd3);
    add(0, 4'b1111, 16'h3012, 1, 4'b1000, 2'd3, 4'd2);
    add(0, 4'b1111, 16'h3012, 1, 4'b1000, 2'd3, 4'd1);
    add(0, 4'b1111, 16'h3012, 1, 4'b0001, 2'd0, 4'd2);
    add(0, 4'b1111, 16'h3012, 1, 4'b0001, 2'd0, 4'd1);
    add(0, 4'b1111, 16'h3012, 1, 4'b0010, 2'd1, 4'd1);
    add(0, 4'b1111, 16'h3012, 1, 4'b1000, 2'd3, 4'd3);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].reqs, tbl[i].q);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].credit);
    end

    // Owner drops its request mid-quantum: no grant, then immediate handover.
    drive(1, 4'b1111, 16'h4444);
    drive(0, 4'b1111, 16'h4444);
    chk("drop_idle", 4'b0000, 2'd3, 4'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'b1111, 16'h4444);
      chk("drop_o0", 4'b0001, 2'd0, 4'(4 - k));
    end
    drive(0, 4'b1111, 16'h4444);
    chk("drop_o1a", 4'b0010, 2'd1, 4'd4);
    drive(0, 4'b1111, 16'h4444);
    chk("drop_o1b", 4'b0010, 2'd1, 4'd3);
    drive(0, 4'b1101, 16'h4444);
    chk("drop_gap", 4'b0000, 2'd1, 4'd2);
    drive(0, 4'b1111, 16'h4444);
    chk("drop_next", 4'b0100, 2'd2, 4'd4);

    // Quantum change during service only applies at the next load.
    drive(1, 4'b1111, 16'h4444);
    drive(0, 4'b1111, 16'h4444);
    chk("qchg_idle", 4'b0000, 2'd3, 4'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'b1111, 16'h4444);
      chk("qchg_o0", 4'b0001, 2'd0, 4'(4 - k));
    end
    for (int k = 0; k < 16; k++) begin
      exp_o[k] = 2'((k / 4) + 1);
      exp_c[k] = 4'(4 - (k % 4));
    end
    exp_o[16] = 2'd1; exp_c[16] = 4'd1;
    exp_o[17] = 2'd2; exp_c[17] = 4'd4;
    for (int k = 0; k < 18; k++) begin
      drive(0, 4'b1111, 16'h4414);
      g = 4'b0001 << exp_o[k];
      chk($sformatf("qchg_%0d", k), g, exp_o[k], exp_c[k]);
    end

    // Reset pulse during owner 2 service aborts and restarts from index 0.
    drive(1, 4'b1111, 16'h2222);
    drive(0, 4'b1111, 16'h2222);
    chk("rst_idle", 4'b0000, 2'd3, 4'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'b1111, 16'h2222);
      g = 4'b0001 << (k / 2);
      chk("rst_pre", g, 2'(k / 2), 4'(2 - (k % 2)));
    end
    drive(1, 4'b1111, 16'h2222);
    chk("rst_o2", 4'b0100, 2'd2, 4'd2);
    drive(0, 4'b1111, 16'h2222);
    chk("rst_abort", 4'b0000, 2'd3, 4'd0);
    drive(0, 4'b1111, 16'h2222);
    chk("rst_restart", 4'b0001, 2'd0, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

`default_nettype wire
